// File: rtl/serial_dac_tx.sv
// serial_dac_tx: stereo serial audio DAC transmitter. Generates bclk and
// dac_lr from clk, serialises samples MSB-first in left-justified or I2S
// framing, and takes sample pairs through a one-deep valid/ready buffer.
module serial_dac_tx #(
    parameter int unsigned DATA_W        = 24,
    parameter int unsigned SLOT_W        = 32,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned UNDERRUN_ZERO = 0
) (
    input  logic              clk,
    input  logic              enable,
    input  logic              mode,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              bclk,
    output logic              dac_lr,
    output logic              serial_dac,
    output logic              frame_start,
    output logic              underrun
);
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W    = $clog2(2 * SLOT_W);
    localparam int unsigned IDX_W    = $clog2(DATA_W);
    localparam int unsigned BIT_LAST = 2 * SLOT_W - 1;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_nxt;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] frame_l;
    logic [DATA_W-1:0] frame_r;
    logic [DATA_W-1:0] frame_l_nxt;
    logic [DATA_W-1:0] frame_r_nxt;
    logic [DATA_W-1:0] slot_s;
    logic              mode_r;
    logic              mode_nxt;
    logic              wrap;
    logic              fall;
    logic              boundary;
    logic              accept;
    logic              hold_full;
    logic              ready_nxt;
    logic              dac_lr_nxt;
    logic              serial_nxt;
    logic              underrun_nxt;
    int unsigned       pos;

    // Next-state: divider, bit counter, buffer/frame loading and next serial bit
    always_comb begin
        wrap         = (div_cnt == DIV_W'(CLK_DIV - 1));
        fall         = wrap && bclk;
        boundary     = fall && (bit_cnt == BIT_W'(BIT_LAST));
        hold_full    = !sample_ready;
        accept       = sample_valid && sample_ready;
        div_nxt      = wrap ? '0 : div_cnt + DIV_W'(1);
        bit_nxt      = bit_cnt;
        frame_l_nxt  = frame_l;
        frame_r_nxt  = frame_r;
        mode_nxt     = mode_r;
        ready_nxt    = sample_ready;
        underrun_nxt = 1'b0;
        serial_nxt   = 1'b0;

        if (fall) begin
            bit_nxt = boundary ? '0 : bit_cnt + BIT_W'(1);
        end

        if (accept) begin
            ready_nxt = 1'b0;
        end

        // Frame boundary: buffered pair wins, then a same-edge offer, else underrun
        if (boundary) begin
            mode_nxt = mode;
            if (hold_full) begin
                frame_l_nxt = hold_l;
                frame_r_nxt = hold_r;
                ready_nxt   = 1'b1;
            end else if (accept) begin
                frame_l_nxt = sample_l;
                frame_r_nxt = sample_r;
                ready_nxt   = 1'b1;
            end else begin
                underrun_nxt = 1'b1;
                if (UNDERRUN_ZERO != 0) begin
                    frame_l_nxt = '0;
                    frame_r_nxt = '0;
                end
            end
        end

        // Bit presented after the next fall, using the frame/mode in force then
        dac_lr_nxt = (bit_nxt < BIT_W'(SLOT_W));
        pos        = dac_lr_nxt ? 32'(bit_nxt) : 32'(bit_nxt) - SLOT_W;
        slot_s     = dac_lr_nxt ? frame_l_nxt : frame_r_nxt;
        if (!mode_nxt) begin
            if (pos < DATA_W) begin
                serial_nxt = slot_s[IDX_W'(DATA_W - 1 - pos)];
            end
        end else begin
            if ((pos != 0) && (pos <= DATA_W)) begin
                serial_nxt = slot_s[IDX_W'(DATA_W - pos)];
            end
        end
    end

    // State and output registers; dac_lr/serial_dac move on the bclk fall edge
    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            bclk         <= 1'b0;
            dac_lr       <= 1'b1;
            serial_dac   <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b1;
            hold_l       <= '0;
            hold_r       <= '0;
            frame_l      <= '0;
            frame_r      <= '0;
            mode_r       <= 1'b0;
        end else begin
            div_cnt      <= div_nxt;
            bit_cnt      <= bit_nxt;
            if (wrap) begin
                bclk <= !bclk;
            end
            if (fall) begin
                dac_lr     <= dac_lr_nxt;
                serial_dac <= serial_nxt;
            end
            if (accept && !boundary) begin
                hold_l <= sample_l;
                hold_r <= sample_r;
            end
            sample_ready <= ready_nxt;
            frame_l      <= frame_l_nxt;
            frame_r      <= frame_r_nxt;
            mode_r       <= mode_nxt;
            frame_start  <= boundary;
            underrun     <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_serial_dac_tx.sv
// Scoreboard bench for serial_dac_tx: two instances (repeat / zero underrun
// policy) share stimulus; a frame-level model queues expected frames and a
// monitor reassembles each frame from bclk rising edges and compares.
module tb_serial_dac_tx;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned SLOT_W  = 32;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned FRAME   = 4 * SLOT_W * CLK_DIV;
    localparam int unsigned NBITS   = 2 * SLOT_W;

    typedef struct packed {
        logic              mode;
        logic              urun;
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } frame_t;

    logic              clk;
    logic              enable;
    logic              mode;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic [1:0]        ready_v;
    logic [1:0]        bclk_v;
    logic [1:0]        lr_v;
    logic [1:0]        sd_v;
    logic [1:0]        fs_v;
    logic [1:0]        ur_v;

    int errors = 0;
    int checks = 0;

    serial_dac_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .UNDERRUN_ZERO(0)) dut0 (
        .clk(clk), .enable(enable), .mode(mode), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(ready_v[0]), .bclk(bclk_v[0]),
        .dac_lr(lr_v[0]), .serial_dac(sd_v[0]), .frame_start(fs_v[0]), .underrun(ur_v[0])
    );

    serial_dac_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .UNDERRUN_ZERO(1)) dut1 (
        .clk(clk), .enable(enable), .mode(mode), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(ready_v[1]), .bclk(bclk_v[1]),
        .dac_lr(lr_v[1]), .serial_dac(sd_v[1]), .frame_start(fs_v[1]), .underrun(ur_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp_v, $time);
        end
    endtask

    // Reference model: boundaries every FRAME clks after release; one-deep buffer rules
    frame_t      exp_q0[$];
    frame_t      exp_q1[$];
    int unsigned m_cyc;
    logic        m_full;
    logic        m_acc;
    logic [DATA_W-1:0] m_hl;
    logic [DATA_W-1:0] m_hr;
    frame_t      m_f0;
    frame_t      m_f1;

    always @(posedge clk or negedge enable) begin
        if (!enable) begin
            m_cyc  = 0;
            m_full = 1'b0;
            m_f0   = '0;
            m_f1   = '0;
            exp_q0 = {};
            exp_q1 = {};
            exp_q0.push_back(m_f0);
            exp_q1.push_back(m_f1);
        end else begin
            m_acc = sample_valid && !m_full;
            m_cyc++;
            if (m_cyc % FRAME == 0) begin
                m_f0.urun = 1'b0;
                m_f1.urun = 1'b0;
                if (m_full) begin
                    m_f0.l = m_hl; m_f0.r = m_hr;
                    m_f1.l = m_hl; m_f1.r = m_hr;
                    m_full = 1'b0;
                end else if (m_acc) begin
                    m_f0.l = sample_l; m_f0.r = sample_r;
                    m_f1.l = sample_l; m_f1.r = sample_r;
                end else begin
                    m_f0.urun = 1'b1;
                    m_f1.urun = 1'b1;
                    m_f1.l = '0;
                    m_f1.r = '0;
                end
                m_f0.mode = mode;
                m_f1.mode = mode;
                exp_q0.push_back(m_f0);
                exp_q1.push_back(m_f1);
            end else if (m_acc) begin
                m_hl   = sample_l;
                m_hr   = sample_r;
                m_full = 1'b1;
            end
        end
    end

    // Monitor: rebuild frames from bclk rises, compare at each frame_start
    int               mi_idx[2];
    int               mi_len[2];
    logic             mi_seen[2];
    logic             mi_uf[2];
    logic             mi_pb[2];
    logic [NBITS-1:0] mi_bits[2];
    logic [NBITS-1:0] mi_lr[2];
    logic [SLOT_W-1:0] mi_ls;
    logic [SLOT_W-1:0] mi_rs;
    frame_t           mi_e;
    logic             mi_have;

    always @(negedge clk or negedge enable) begin
        for (int i = 0; i < 2; i++) begin
            if (!enable) begin
                mi_idx[i]  = 0;
                mi_len[i]  = 0;
                mi_seen[i] = 1'b0;
                mi_uf[i]   = 1'b0;
                mi_pb[i]   = 1'b0;
                mi_bits[i] = '0;
                mi_lr[i]   = '0;
            end else begin
                mi_len[i]++;
                check("ready", i, 64'(ready_v[i]), 64'(!m_full));
                if (fs_v[i]) begin
                    if (mi_seen[i]) check("frame_len", i, 64'(mi_len[i]), 64'(FRAME));
                    check("bits_per_frame", i, 64'(mi_idx[i]), 64'(NBITS));
                    mi_have = 1'b0;
                    if (i == 0 && exp_q0.size() > 0) begin mi_e = exp_q0.pop_front(); mi_have = 1'b1; end
                    if (i == 1 && exp_q1.size() > 0) begin mi_e = exp_q1.pop_front(); mi_have = 1'b1; end
                    check("queue_has_frame", i, 64'(mi_have), 64'(1));
                    if (mi_have) begin
                        mi_ls = SLOT_W'(mi_e.l) << (SLOT_W - DATA_W - (mi_e.mode ? 1 : 0));
                        mi_rs = SLOT_W'(mi_e.r) << (SLOT_W - DATA_W - (mi_e.mode ? 1 : 0));
                        check("frame_data", i, 64'(mi_bits[i]), 64'({mi_ls, mi_rs}));
                        check("lr_pattern", i, 64'(mi_lr[i]), 64'({{SLOT_W{1'b1}}, {SLOT_W{1'b0}}}));
                        check("underrun_flag", i, 64'(mi_uf[i]), 64'(mi_e.urun));
                    end
                    mi_seen[i] = 1'b1;
                    mi_len[i]  = 0;
                    mi_idx[i]  = 0;
                    mi_uf[i]   = ur_v[i];
                end else begin
                    check("underrun_pulse", i, 64'(ur_v[i]), 64'(0));
                end
                if (bclk_v[i] && !mi_pb[i]) begin
                    mi_bits[i] = {mi_bits[i][NBITS-2:0], sd_v[i]};
                    mi_lr[i]   = {mi_lr[i][NBITS-2:0], lr_v[i]};
                    mi_idx[i]++;
                end
                mi_pb[i] = bclk_v[i];
            end
        end
    end

    // Offer a pair at a negedge and hold valid until the DUT takes it
    task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        logic rd;
        int   n;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        n = 0;
        do begin
            rd = ready_v[0];
            @(posedge clk);
            n++;
        end while (!rd && n < int'(3 * FRAME));
        check("handshake", 0, 64'(rd), 64'(1));
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned target);
        int n;
        n = 0;
        while (m_cyc < target && n < 100000) begin
            @(negedge clk);
            n++;
        end
        if (m_cyc < target) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached %0d required %0d", m_cyc, target);
        end
    endtask

    task automatic wait_off(input int unsigned off);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((m_cyc % FRAME) != off && n < int'(2 * FRAME));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        enable       = 1'b0;
        mode         = 1'b0;
        sample_valid = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_bclk", i, 64'(bclk_v[i]), 64'(0));
            check("rst_dac_lr", i, 64'(lr_v[i]), 64'(1));
            check("rst_serial", i, 64'(sd_v[i]), 64'(0));
            check("rst_frame_start", i, 64'(fs_v[i]), 64'(0));
            check("rst_underrun", i, 64'(ur_v[i]), 64'(0));
            check("rst_ready", i, 64'(ready_v[i]), 64'(1));
        end

        // Left-justified A, then B and C back-to-back under backpressure
        enable = 1'b1;
        send(24'hA5A5A5, 24'h5A5A5A);
        send(24'h0F1E2D, 24'h3C4B5A);
        send(24'hC0FFEE, 24'h1234AB);

        // Idle through an underrun, then I2S pair with a mid-frame mode flip
        wait_cyc(FRAME * 4 + 50);
        mode = 1'b1;
        send(24'h800001, DATA_W'($urandom));
        wait_cyc(FRAME * 5 + 100);
        mode = 1'b0;

        // Offer lands exactly on a boundary edge with the buffer empty
        wait_cyc(FRAME * 7 - 1);
        send(24'h123456, DATA_W'($urandom));
        for (int i = 0; i < 2; i++) check("collision_ready", i, 64'(ready_v[i]), 64'(1));

        // Random pairs, gaps and mode changes
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) mode = ~mode;
            send(DATA_W'($urandom), DATA_W'($urandom));
        end

        // Mid-frame reset with bclk high, bit 40, buffer full
        mode = 1'b0;
        wait_cyc(m_cyc + 2 * FRAME);
        wait_off(10);
        send(DATA_W'($urandom), '1);
        wait_off(10);
        send(DATA_W'($urandom), DATA_W'($urandom));
        wait_off(162);
        for (int i = 0; i < 2; i++) begin
            check("pre_bclk", i, 64'(bclk_v[i]), 64'(1));
            check("pre_dac_lr", i, 64'(lr_v[i]), 64'(0));
            check("pre_serial", i, 64'(sd_v[i]), 64'(1));
            check("pre_ready", i, 64'(ready_v[i]), 64'(0));
        end
        #1 enable = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_bclk", i, 64'(bclk_v[i]), 64'(0));
            check("async_dac_lr", i, 64'(lr_v[i]), 64'(1));
            check("async_serial", i, 64'(sd_v[i]), 64'(0));
            check("async_ready", i, 64'(ready_v[i]), 64'(1));
        end
        @(negedge clk);
        enable = 1'b1;
        for (int e = 1; e <= int'(CLK_DIV); e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) check("first_rise", i, 64'(bclk_v[i]), 64'(e == int'(CLK_DIV)));
        end
        wait_cyc(FRAME + 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_dac_tx.md
Name: serial_dac_tx

Overview:
- Parametrised next-generation serial audio DAC transmitter for the DE1-SoC audio path.
- Generates its own bit clock (bclk) and channel select (dac_lr) from clk.
- Serialises stereo samples MSB-first in left-justified or I2S framing.
- Accepts samples through a one-deep valid/ready holding buffer, with defined underrun behaviour.

Parameters:
- DATA_W, 24, sample width per channel (8..32).
- SLOT_W, 32, bclk periods per channel slot. Must be >= DATA_W+1.
- CLK_DIV, 4, clk cycles per bclk half-period (>=1). One bclk period = 2*CLK_DIV clk cycles.
- UNDERRUN_ZERO, 0, underrun policy: 0 repeats the last frame, 1 sends zeros.

Ports:
- clk, input, 1, system clock.
- enable, input, 1, master reset. Asynchronous, active-low.
- mode, input, 1, framing: 0 = left-justified, 1 = I2S.
- sample_l, input, DATA_W, left sample.
- sample_r, input, DATA_W, right sample.
- sample_valid, input, 1, sample pair offered.
- sample_ready, output, 1, holding buffer empty.
- bclk, output, 1, serial bit clock. Data changes on the falling edge; the DAC samples on the rising edge.
- dac_lr, output, 1, channel select: 1 = left slot, 0 = right slot.
- serial_dac, output, 1, serial data.
- frame_start, output, 1, one-clk pulse at each frame boundary.
- underrun, output, 1, one-clk pulse when a boundary finds no data.

Behaviour:
- Reset (enable=0, asynchronous, takes effect immediately, including mid-frame):
  - bclk=0, dac_lr=1, serial_dac=0, frame_start=0, underrun=0.
  - div_cnt=0, bit_cnt=0, hold_full=0, frame regs=0, mode_r=0.
  - sample_ready=1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps. At wrap, bclk toggles.
  - Fall event: a wrap with bclk=1.
- Bit counter:
  - bit_cnt (0..2*SLOT_W-1) advances on each fall event and wraps to 0.
  - Boundary: a fall event where bit_cnt = 2*SLOT_W-1.
- Registered outputs: dac_lr and serial_dac are registered and update on the same clk edge as bclk's fall. There is no skew between them.
- Slot position:
  - dac_lr = 1 when the next bit_cnt < SLOT_W, else 0.
  - Slot position p = bit_cnt mod SLOT_W.
- Bit mapping, with s = the slot's channel sample (frame_l when dac_lr=1, frame_r when dac_lr=0):
  - Left-justified (mode_r=0): serial_dac = s[DATA_W-1-p] for p<DATA_W, else 0.
  - I2S (mode_r=1): serial_dac = s[DATA_W-p] for 1<=p<=DATA_W, else 0. This is a one-bit delay after the dac_lr transition.
- mode is sampled into mode_r only at a boundary. A mid-frame change has no effect until the next frame.
- Handshake:
  - sample_ready = !hold_full.
  - Accept = sample_valid && sample_ready on a clk edge. On accept, hold_l/hold_r capture the inputs and hold_full is set.
  - Inputs are ignored while sample_ready=0.
- At each boundary clk edge:
  - If hold_full: frame regs load from hold, and hold_full is cleared.
  - Else if accept occurs on the same edge: frame regs load directly from sample_l/r. hold_full stays 0 and there is no underrun.
  - Else (underrun): underrun pulses for 1 clk. Frame regs keep their value if UNDERRUN_ZERO=0, or clear to 0 if UNDERRUN_ZERO=1.
  - frame_start pulses for 1 clk.
  - serial_dac for p=0 of the new left slot reflects the newly loaded frame.
- Accept on a boundary edge with hold_full=1 is impossible, because ready=0.
- After reset, the first frame transmits zeros. The first boundary applies the load/underrun rules above.
- Frame period = 4*SLOT_W*CLK_DIV clk cycles. The default is 512.

Test Plan:
- Reset mid-frame:
  - Stimulus: drop enable with bclk=1 and bit_cnt=40.
  - Required: in the same cycle, bclk=0, dac_lr=1, serial_dac=0, sample_ready=1.
  - Required after release: bclk first rises after CLK_DIV clks.
- Left-justified framing (CLK_DIV=2):
  - Stimulus: L=0xA5A5A5, R=0x5A5A5A, accepted before the first boundary.
  - Required, next frame: dac_lr=1 for 32 bclks carrying 1010_0101... MSB-first, then p24..31=0.
  - Required: dac_lr=0 slot carries 0x5A5A5A.
  - Required: frame length is 256 clk.
- I2S framing:
  - Stimulus: mode=1, L=0x800001.
  - Required, left slot: p0=0, p1=1, p2..23=0, p24=1, p25..31=0.
  - Stimulus: toggle mode mid-frame.
  - Required: framing changes only after the next frame_start.
- Backpressure:
  - Stimulus: offer pairs A, B, C back-to-back with valid held.
  - Required: A is accepted and ready falls.
  - Required: B is accepted only on the clk after the boundary that loads A; C waits one more frame.
  - Required: output order is A, B, C.
- Underrun:
  - Stimulus: no samples offered after pair A.
  - Required: at the next boundary underrun=1 for 1 clk.
  - Required: the frame repeats A with UNDERRUN_ZERO=0, and is all zeros with UNDERRUN_ZERO=1.
- Boundary collision:
  - Stimulus: hold empty, valid asserted exactly on the boundary edge with L=0x123456.
  - Required: that frame transmits 0x123456 and underrun=0.
  - Required: ready stays 1.
